// File: rtl/ct_ifu_spsram_1024x59_ctrl_if.sv
// Request, response and SRAM-pin bundle for the IFU 1024x59 SRAM controller.
// slave = controller side, master = pipeline/refill/SRAM-model side.
interface ct_ifu_spsram_1024x59_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 59
);
  logic                  inv_all_req;
  logic                  inv_busy;
  logic                  inv_done;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  wr_ack;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ack;
  logic                  rd_data_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_par_err;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_q;

  modport slave (
    input  inv_all_req, wr_req, wr_addr, wr_data, wr_mask, rd_req, rd_addr, sram_q,
    output inv_busy, inv_done, wr_ack, rd_ack, rd_data_vld, rd_data, rd_par_err,
           sram_a, sram_cen, sram_gwen, sram_d, sram_wen
  );

  modport master (
    output inv_all_req, wr_req, wr_addr, wr_data, wr_mask, rd_req, rd_addr, sram_q,
    input  inv_busy, inv_done, wr_ack, rd_ack, rd_data_vld, rd_data, rd_par_err,
           sram_a, sram_cen, sram_gwen, sram_d, sram_wen
  );
endinterface

// File: rtl/ct_ifu_spsram_1024x59_ctrl.sv
// Single-port IFU SRAM controller: write/read arbitration with read anti-starvation, invalidate sweep.
// Acks are same-cycle comb; read data valid 1 cycle after rd_ack. Optional parity: CT_IFU_SRAM_PARITY_EN.
module ct_ifu_spsram_1024x59_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 59,
  parameter int STARVE_LIMIT = 2
) (
  input logic forever_cpuclk,
  input logic cpurst_b,
  ct_ifu_spsram_1024x59_ctrl_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {SWEEP = 1'b0, IDLE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [SW-1:0]         starve_cnt;
  logic                  inv_done_q, rd_vld_q;
  logic                  rd_win, rd_ack_c, wr_ack_c;
  logic [ADDR_WIDTH-1:0] a_c;
  logic                  cen_c, gwen_c;
  logic [DATA_WIDTH-1:0] d_c, wen_c, wr_d_eff, wr_m_eff;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state_q <= SWEEP;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SWEEP:   if (&sweep_cnt) state_d = IDLE;
      IDLE:    if (bus.inv_all_req) state_d = SWEEP;
      default: state_d = SWEEP;
    endcase
  end

  always_comb begin
    rd_win   = bus.rd_req && (!bus.wr_req || starve_cnt == SW'(STARVE_LIMIT));
    // An invalidate request owns its cycle so a pending read cannot slip in ahead of the sweep.
    rd_ack_c = (state_q == IDLE) && !bus.inv_all_req && rd_win;
    wr_ack_c = (state_q == IDLE) && !bus.inv_all_req && bus.wr_req && !rd_win;
    a_c      = '0;
    cen_c    = 1'b1;
    gwen_c   = 1'b1;
    d_c      = '0;
    wen_c    = '1;
    if (state_q == SWEEP && cpurst_b) begin
      a_c    = sweep_cnt;
      cen_c  = 1'b0;
      gwen_c = 1'b0;
      wen_c  = '0;
    end else if (wr_ack_c) begin
      a_c    = bus.wr_addr;
      cen_c  = 1'b0;
      gwen_c = 1'b0;
      d_c    = wr_d_eff;
      wen_c  = ~wr_m_eff;
    end else if (rd_ack_c) begin
      a_c    = bus.rd_addr;
      cen_c  = 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      sweep_cnt  <= '0;
      starve_cnt <= '0;
      inv_done_q <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      sweep_cnt  <= (state_q == SWEEP) ? sweep_cnt + 1'b1 : '0;
      inv_done_q <= (state_q == SWEEP) && (&sweep_cnt);
      rd_vld_q   <= rd_ack_c;
      if (rd_ack_c)
        starve_cnt <= '0;
      else if (bus.rd_req && wr_ack_c && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef CT_IFU_SRAM_PARITY_EN
  // MSB carries even parity; it is written whenever any data bit is written.
  assign wr_d_eff       = {^bus.wr_data[DATA_WIDTH-2:0], bus.wr_data[DATA_WIDTH-2:0]};
  assign wr_m_eff       = {|bus.wr_mask[DATA_WIDTH-2:0], bus.wr_mask[DATA_WIDTH-2:0]};
  assign bus.rd_par_err = rd_vld_q & (^bus.sram_q);
`else
  assign wr_d_eff       = bus.wr_data;
  assign wr_m_eff       = bus.wr_mask;
  assign bus.rd_par_err = 1'b0;
`endif

  assign bus.inv_busy    = (state_q == SWEEP);
  assign bus.inv_done    = inv_done_q;
  assign bus.wr_ack      = wr_ack_c;
  assign bus.rd_ack      = rd_ack_c;
  assign bus.rd_data_vld = rd_vld_q;
  assign bus.rd_data     = bus.sram_q;
  assign bus.sram_a      = a_c;
  assign bus.sram_cen    = cen_c;
  assign bus.sram_gwen   = gwen_c;
  assign bus.sram_d      = d_c;
  assign bus.sram_wen    = wen_c;
endmodule

// File: tb/tb_ct_ifu_spsram_1024x59_ctrl.sv
// Bench for ct_ifu_spsram_1024x59_ctrl with a behavioural 1024x59 SRAM attached.
module tb_ct_ifu_spsram_1024x59_ctrl;
  localparam int AW = 10;
  localparam int DW = 59;
`ifdef CT_IFU_SRAM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] P55  = 59'h555_5555_5555_5555;
  localparam logic [DW-1:0] M0FF = 59'h0FF;
  localparam logic [DW-1:0] PM   = {PAR_ON, {(DW-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ct_ifu_spsram_1024x59_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ct_ifu_spsram_1024x59_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(2)) dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rst_n),
    .bus           (bus)
  );

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] q_r  = '0;
  logic [DW-1:0] flip = '0;
  always @(posedge clk) begin
    if (!bus.sram_cen) begin
      if (!bus.sram_gwen)
        mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
      else
        q_r <= mem[bus.sram_a];
    end
  end
  assign bus.sram_q = q_r ^ flip;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          wr_req, rd_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data, wr_mask;
    logic [AW-1:0] rd_addr;
    logic          e_wr_ack, e_rd_ack, e_cen, e_gwen;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d, e_wen;
    logic          e_vld;
    logic [DW-1:0] e_q;
  } vec_t;

  vec_t tbl [12];

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    int k;
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_mask = m;
    #1;
    k = 0;
    while (!bus.wr_ack && k < 50) begin @(negedge clk); #1; k++; end
    chk("wr_ack_wait", 64'(k < 50), 64'd1);
    @(negedge clk);
    bus.wr_req = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic exp_par);
    int k;
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = a;
    #1;
    k = 0;
    while (!bus.rd_ack && k < 50) begin @(negedge clk); #1; k++; end
    chk({nm, "_ack_wait"}, 64'(k < 50), 64'd1);
    @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    chk({nm, "_vld"}, 64'(bus.rd_data_vld), 64'd1);
    chk({nm, "_data"}, 64'(bus.rd_data), 64'(exp));
    chk({nm, "_par"}, 64'(bus.rd_par_err), 64'(exp_par));
  endtask

  initial begin
    int bad, dcnt, k;
    //          wr   rd   wr_addr  wr_data wr_mask rd_addr  wa   ra   cen  gwen e_a      e_d   e_wen          vld  e_q
    tbl[0]  = '{1'b0,1'b0,10'h000, '0,     '0,     10'h000, 1'b0,1'b0,1'b1,1'b1,10'h000, '0,   ONES,          1'b0,'0};
    tbl[1]  = '{1'b1,1'b0,10'h3FF, P55,    ONES,   10'h000, 1'b1,1'b0,1'b0,1'b0,10'h3FF, P55,  '0,            1'b0,'0};
    tbl[2]  = '{1'b0,1'b1,10'h000, '0,     '0,     10'h3FF, 1'b0,1'b1,1'b0,1'b1,10'h3FF, '0,   ONES,          1'b0,'0};
    tbl[3]  = '{1'b1,1'b1,10'h001, M0FF,   M0FF,   10'h002, 1'b1,1'b0,1'b0,1'b0,10'h001, M0FF, ~(M0FF | PM),  1'b1,P55};
    tbl[4]  = '{1'b1,1'b1,10'h003, '0,     '0,     10'h002, 1'b1,1'b0,1'b0,1'b0,10'h003, '0,   ONES,          1'b0,'0};
    tbl[5]  = '{1'b1,1'b1,10'h003, '0,     '0,     10'h002, 1'b0,1'b1,1'b0,1'b1,10'h002, '0,   ONES,          1'b0,'0};
    tbl[6]  = '{1'b1,1'b1,10'h003, '0,     '0,     10'h001, 1'b1,1'b0,1'b0,1'b0,10'h003, '0,   ONES,          1'b1,'0};
    tbl[7]  = '{1'b0,1'b1,10'h000, '0,     '0,     10'h001, 1'b0,1'b1,1'b0,1'b1,10'h001, '0,   ONES,          1'b0,'0};
    tbl[8]  = '{1'b1,1'b1,10'h007, '0,     '0,     10'h006, 1'b1,1'b0,1'b0,1'b0,10'h007, '0,   ONES,          1'b1,M0FF};
    tbl[9]  = '{1'b1,1'b1,10'h007, '0,     '0,     10'h006, 1'b1,1'b0,1'b0,1'b0,10'h007, '0,   ONES,          1'b0,'0};
    tbl[10] = '{1'b1,1'b1,10'h007, '0,     '0,     10'h006, 1'b0,1'b1,1'b0,1'b1,10'h006, '0,   ONES,          1'b0,'0};
    tbl[11] = '{1'b0,1'b0,10'h000, '0,     '0,     10'h000, 1'b0,1'b0,1'b1,1'b1,10'h000, '0,   ONES,          1'b1,'0};

    bus.inv_all_req = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0; bus.rd_addr = '0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cen", 64'(bus.sram_cen), 64'd1);
    chk("rst_busy", 64'(bus.inv_busy), 64'd1);
    chk("rst_vld", 64'(bus.rd_data_vld), 64'd0);
    chk("rst_done", 64'(bus.inv_done), 64'd0);
    chk("rst_acks", 64'({bus.wr_ack, bus.rd_ack}), 64'd0);

    // Power-on sweep: one zero write per entry, in address order.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    bad = 0; dcnt = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!(bus.inv_busy && !bus.sram_cen && !bus.sram_gwen && bus.sram_a == AW'(i) &&
            bus.sram_wen == '0 && bus.sram_d == '0)) bad++;
      dcnt += int'(bus.inv_done);
      @(negedge clk);
      #1;
    end
    chk("sweep_bad_cycles", 64'(bad), 64'd0);
    chk("sweep_done_early", 64'(dcnt), 64'd0);
    chk("sweep_end_busy", 64'(bus.inv_busy), 64'd0);
    chk("sweep_done_pulse", 64'(bus.inv_done), 64'd1);
    @(negedge clk);
    #1;
    chk("sweep_done_clear", 64'(bus.inv_done), 64'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.wr_req  = tbl[i].wr_req;  bus.rd_req  = tbl[i].rd_req;
      bus.wr_addr = tbl[i].wr_addr; bus.wr_data = tbl[i].wr_data;
      bus.wr_mask = tbl[i].wr_mask; bus.rd_addr = tbl[i].rd_addr;
      #1;
      chk($sformatf("v%0d_wr_ack", i), 64'(bus.wr_ack), 64'(tbl[i].e_wr_ack));
      chk($sformatf("v%0d_rd_ack", i), 64'(bus.rd_ack), 64'(tbl[i].e_rd_ack));
      chk($sformatf("v%0d_cen", i), 64'(bus.sram_cen), 64'(tbl[i].e_cen));
      chk($sformatf("v%0d_gwen", i), 64'(bus.sram_gwen), 64'(tbl[i].e_gwen));
      chk($sformatf("v%0d_a", i), 64'(bus.sram_a), 64'(tbl[i].e_a));
      chk($sformatf("v%0d_d", i), 64'(bus.sram_d), 64'(tbl[i].e_d));
      chk($sformatf("v%0d_wen", i), 64'(bus.sram_wen), 64'(tbl[i].e_wen));
      chk($sformatf("v%0d_vld", i), 64'(bus.rd_data_vld), 64'(tbl[i].e_vld));
      if (tbl[i].e_vld)
        chk($sformatf("v%0d_rdata", i), 64'(bus.rd_data), 64'(tbl[i].e_q));
    end
    @(negedge clk);
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;

    // Masked write only updates the low byte.
    do_write(10'd5, ONES, ONES);
    do_write(10'd5, '0, M0FF);
    rd_chk("masked", 10'd5, 59'h7FF_FFFF_FFFF_FF00 & ~PM, 1'b0);

    // Read then write to the same entry: read returns the pre-write word.
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = 10'd5;
    #1;
    chk("order_rd_ack", 64'(bus.rd_ack), 64'd1);
    @(negedge clk);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = '0; bus.wr_mask = ONES;
    #1;
    chk("order_wr_ack", 64'(bus.wr_ack), 64'd1);
    chk("order_vld", 64'(bus.rd_data_vld), 64'd1);
    chk("order_old_data", 64'(bus.rd_data), 64'(59'h7FF_FFFF_FFFF_FF00 & ~PM));
    @(negedge clk);
    bus.wr_req = 1'b0;
    rd_chk("order_new", 10'd5, '0, 1'b0);

    // Corrupted Q bit raises parity error only when parity is built in.
    flip = 59'h8;
    rd_chk("par_flip", 10'h3FF, P55 ^ 59'h8, PAR_ON);
    flip = '0;
    rd_chk("par_clean", 10'h3FF, P55, 1'b0);

    // Invalidate with a read pending: read waits out the whole sweep.
    @(negedge clk);
    bus.inv_all_req = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 10'h3FF;
    #1;
    k = 0;
    while (!bus.rd_ack && k < 3000) begin
      @(negedge clk);
      bus.inv_all_req = 1'b0;
      #1;
      k++;
    end
    chk("inv_rd_wait", 64'(k), 64'd1025);
    @(negedge clk);
    bus.inv_all_req = 1'b0; bus.rd_req = 1'b0;
    #1;
    chk("inv_rd_vld", 64'(bus.rd_data_vld), 64'd1);
    chk("inv_rd_data", 64'(bus.rd_data), 64'd0);

    // Reset in the middle of a sweep restarts it from entry 0.
    @(negedge clk);
    bus.inv_all_req = 1'b1;
    @(negedge clk);
    bus.inv_all_req = 1'b0;
    #1;
    k = 0;
    while (!(bus.inv_busy && bus.sram_a == 10'd500) && k < 2000) begin @(negedge clk); #1; k++; end
    chk("mid_reach500", 64'(k), 64'd500);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cen", 64'(bus.sram_cen), 64'd1);
    chk("mid_rst_busy", 64'(bus.inv_busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_restart_a", 64'(bus.sram_a), 64'd0);
    chk("mid_restart_cen", 64'(bus.sram_cen), 64'd0);
    k = 0;
    while (bus.inv_busy && k < 2000) begin @(negedge clk); #1; k++; end
    chk("mid_sweep_len", 64'(k), 64'd1024);
    chk("mid_done_pulse", 64'(bus.inv_done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
